cache_refill_master: RTL and testbench
======================================

Name: cache_refill_master

Overview:
- Memory-side line-fill engine directly downstream of the direct-mapped cache.
- On a cache miss the cache hands it a line address. The block issues one single-beat AXI4-lite read per word of the line to the memory-side slave and writes each returned word into the cache data array.
- Signals completion and reports the error status back to the cache.
- AXI4-lite has no bursts, so a line is LINE_WORDS sequential AR/R transactions, with one outstanding at a time.

Parameters:
- ADDR_W, 32, byte address width of request and AXI address.
- DATA_W, 32, word width; byte stride between words = DATA_W/8.
- LINE_WORDS, 4, words per cache line; power of two, >= 1.
- IDX_W, $clog2(LINE_WORDS) (min 1), word-index width within a line.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); synchronous release by the system.
- req_valid  in  1  cache requests a line refill.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  any byte address inside the target line; low bits are ignored.
- m_ar_addr  out  ADDR_W  AXI read address, word-aligned.
- m_ar_valid  out  1  AXI read address valid.
- m_ar_ready  in  1  AXI read address ready.
- m_r_data  in  DATA_W  AXI read data.
- m_r_resp  in  2  AXI read response; 2'b00 = OKAY.
- m_r_valid  in  1  AXI read data valid.
- m_r_ready  out  1  AXI read data ready.
- fill_we  out  1  one-cycle write strobe to the cache data array.
- fill_idx  out  IDX_W  word index within the line for fill_we.
- fill_data  out  DATA_W  word to write.
- done  out  1  one-cycle pulse: line complete.
- done_err  out  1  valid with done; 1 if any beat returned non-OKAY.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0 except req_ready=1.
  - Word counter, base address and error flag cleared.
  - An in-flight AXI transaction is abandoned; the memory slave is reset by the same rst.
- State IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch base = req_addr with the low log2(LINE_WORDS*DATA_W/8) bits forced to 0; clear idx and err; go to AR.
- State AR:
  - m_ar_valid=1, m_ar_addr = base + idx*(DATA_W/8), computed mod 2^ADDR_W.
  - Address and valid are held stable until m_ar_ready.
  - On handshake, go to R next cycle; m_ar_valid drops that same edge.
- State R:
  - m_r_ready=1.
  - On m_r_valid:
    - Register fill_we=1, fill_idx=idx, fill_data=m_r_data for exactly the next cycle.
    - err |= (m_r_resp != 2'b00).
    - If idx != LINE_WORDS-1: idx++, go to AR.
    - Else go to DONE.
- State DONE:
  - Lasts 1 cycle; this cycle carries the last fill_we.
  - done=1, done_err=err (including the last beat's response); then go to IDLE.
- m_r_ready=0 outside R; m_r_valid in IDLE/AR/DONE is ignored, with no state change.
- m_ar_ready while m_ar_valid=0 is ignored.
- Non-OKAY beats do not abort the refill: all LINE_WORDS beats are read and written; the cache decides on done_err.
- fill_we is never asserted in two consecutive cycles.
- Outside the fill strobe, fill_idx and fill_data hold their last value.
- Latency with a zero-wait slave (request accepted at cycle 0):
  - Word k: AR at cycle 1+2k, fill_we at cycle 3+2k.
  - done at cycle 1+2*LINE_WORDS (cycle 9 for LINE_WORDS=4).
  - req_ready=1 again at cycle 2+2*LINE_WORDS.
- A new req_valid while busy is not accepted (req_ready=0); the cache must hold it.
- Address wrap: a line at the top of the address space is computed mod 2^ADDR_W. Wrap cannot occur inside an aligned line.

Test Plan:
- Zero-wait slave, req_addr=0x0000_0047, LINE_WORDS=4:
  - AR addresses 0x40, 0x44, 0x48, 0x4C in order.
  - fill_idx 0..3 carry mem[0x40..0x4C].
  - done=1 at cycle 9 with done_err=0; req_ready=1 at cycle 10.
- Slave with 3-cycle m_ar_ready delay and 2-cycle m_r_valid delay per beat:
  - m_ar_addr/m_ar_valid stay stable while waiting.
  - Exactly 4 fill_we pulses; done once.
- Second beat returns m_r_resp=2'b10:
  - All 4 words are still written.
  - done_err=1 with done.
  - The next clean refill gives done_err=0.
- rst=0 asserted while in R after 2 beats:
  - Outputs clear immediately (asynchronously), with no done pulse.
  - After release, a fresh request at 0x80 completes normally.
- req_valid held high continuously, with a spurious m_r_valid in IDLE:
  - Back-to-back refills with exactly one IDLE cycle between.
  - The spurious m_r_valid is ignored and produces no fill_we.
- req_addr=0xFFFF_FFF4:
  - Addresses 0xFFFF_FFF0..0xFFFF_FFFC, with no wrap to 0.

Source files
------------

// File: rtl/cache_refill_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_refill_master
// Brief    : Line-fill engine. Reads one cache line as LINE_WORDS single-beat
//            AXI4-lite reads and streams each word into the cache data array.
// Revision : 1.0  initial release
// ============================================================================
module cache_refill_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              done,
  output logic              done_err
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int OFFS_W  = $clog2(LINE_WORDS * (DATA_W / 8));
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((64'd1 << OFFS_W) - 64'd1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_idx;
  logic              r_err;
  logic              r_fill_we;
  logic [IDX_W-1:0]  r_fill_idx;
  logic [DATA_W-1:0] r_fill_data;

  logic [ADDR_W-1:0] w_line_base;

  assign w_line_base = req_addr & ~OFFS_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_fill_we   <= 1'b0;
      r_fill_idx  <= '0;
      r_fill_data <= '0;
    end else begin
      // Strobe is a single-cycle pulse; idx/data keep their last value.
      r_fill_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_base  <= w_line_base;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_state <= ST_AR;
          end
        end
        ST_AR: begin
          if (m_ar_ready) begin
            r_state <= ST_R;
          end
        end
        ST_R: begin
          if (m_r_valid) begin
            r_fill_we   <= 1'b1;
            r_fill_idx  <= r_idx;
            r_fill_data <= m_r_data;
            r_err       <= r_err | (m_r_resp != 2'b00);
            if (r_idx == LAST_IDX) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_AR;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign m_ar_valid = (r_state == ST_AR);
  assign m_ar_addr  = r_base + (ADDR_W'(r_idx) << BYTE_SH);
  assign m_r_ready  = (r_state == ST_R);
  assign fill_we    = r_fill_we;
  assign fill_idx   = r_fill_idx;
  assign fill_data  = r_fill_data;
  assign done       = (r_state == ST_DONE);
  assign done_err   = (r_state == ST_DONE) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_master
// Brief    : Directed self-checking bench with a configurable-latency slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_refill_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] m_ar_addr;
  logic        m_ar_valid;
  logic        m_ar_ready;
  logic [31:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_valid;
  logic        m_r_ready;
  logic        fill_we;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        done;
  logic        done_err;

  cache_refill_master #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid),
    .m_r_ready(m_r_ready),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
    .done(done), .done_err(done_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave configuration (written by the main sequence only)
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [31:0] err_addr = 32'h1;
  int          spur_req = 0;

  // Slave state and logs (written by the slave only)
  int          spur_served = 0;
  int          unstable = 0;
  logic [31:0] ar_log[$];

  // Memory content: word at address a is ~a.
  initial begin
    logic [31:0] a;
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b0;
    m_r_data   = '0;
    m_r_resp   = 2'b00;
    forever begin
      @(negedge clk);
      if (spur_served != spur_req) begin
        m_r_valid = 1'b1;
        m_r_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        m_r_valid = 1'b0;
        spur_served++;
      end
      while (m_ar_valid) begin
        a = m_ar_addr;
        repeat (ar_delay) begin
          @(negedge clk);
          if (!m_ar_valid || m_ar_addr != a) unstable++;
        end
        m_ar_ready = 1'b1;
        ar_log.push_back(a);
        @(negedge clk);
        m_ar_ready = 1'b0;
        repeat (r_delay) @(negedge clk);
        m_r_valid = 1'b1;
        m_r_data  = ~a;
        m_r_resp  = (a == err_addr) ? 2'b10 : 2'b00;
        @(negedge clk);
        m_r_valid = 1'b0;
        m_r_resp  = 2'b00;
      end
    end
  end

  // Monitor: samples on the falling edge
  int          cyc = 0;
  int          done_n = 0;
  int          consec = 0;
  logic [31:0] f_idx[$];
  logic [31:0] f_data[$];
  int          f_cyc[$];
  logic        dq[$];
  int          done_cyc[$];
  int          acc_q[$];
  int          rdy_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    logic prev_we;
    logic prev_rdy;
    prev_we  = 1'b0;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (fill_we) begin
        f_idx.push_back(32'(fill_idx));
        f_data.push_back(fill_data);
        f_cyc.push_back(cyc);
        if (prev_we) consec++;
      end
      prev_we = fill_we;
      if (done) begin
        done_n++;
        dq.push_back(done_err);
        done_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (req_ready && !prev_rdy) rdy_q.push_back(cyc);
      prev_rdy = req_ready;
    end
  end

  task automatic refill(input logic [31:0] a);
    int n0, d0, k;
    n0 = acc_q.size();
    d0 = done_n;
    @(posedge clk); #1;
    req_addr  = a;
    req_valid = 1'b1;
    k = 0;
    while (acc_q.size() == n0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    req_valid = 1'b0;
    chk("accept_timeout", 32'(k < 50), 32'd1);
    k = 0;
    while (done_n == d0 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_timeout", 32'(k < 500), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int fb, ab, db, qb, rb, ub, d0, k;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;

    // Reset state
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_ar_valid", 32'(m_ar_valid), 32'd0);
    chk("rst_ar_addr", m_ar_addr, 32'd0);
    chk("rst_r_ready", 32'(m_r_ready), 32'd0);
    chk("rst_fill_we", 32'(fill_we), 32'd0);
    chk("rst_done", 32'({done, done_err}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Zero-wait slave, unaligned request address
    fb = f_idx.size(); ab = ar_log.size(); qb = acc_q.size(); db = dq.size();
    rb = rdy_q.size();
    refill(32'h0000_0047);
    chk("t1_ar0", ar_log[ab+0], 32'h40);
    chk("t1_ar1", ar_log[ab+1], 32'h44);
    chk("t1_ar2", ar_log[ab+2], 32'h48);
    chk("t1_ar3", ar_log[ab+3], 32'h4C);
    chk("t1_nfill", 32'(f_idx.size() - fb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_idx", f_idx[fb+i], 32'(i));
      chk("t1_fcyc", 32'(f_cyc[fb+i] - acc_q[qb]), 32'(3 + 2 * i));
    end
    chk("t1_d0", f_data[fb+0], 32'hFFFF_FFBF);
    chk("t1_d3", f_data[fb+3], 32'hFFFF_FFB3);
    chk("t1_done_cyc", 32'(done_cyc[db] - acc_q[qb]), 32'd9);
    chk("t1_done_err", 32'(dq[db]), 32'd0);
    chk("t1_ready_cyc", 32'(rdy_q[rb] - acc_q[qb]), 32'd10);

    // Slow slave: address must stay stable while waiting
    ar_delay = 3; r_delay = 2;
    fb = f_idx.size(); ub = unstable; d0 = done_n;
    refill(32'h0000_0100);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_nfill", 32'(f_idx.size() - fb), 32'd4);
    chk("t2_ndone", 32'(done_n - d0), 32'd1);
    chk("t2_unstable", 32'(unstable - ub), 32'd0);
    chk("t2_idx3", f_idx[fb+3], 32'd3);
    chk("t2_d1", f_data[fb+1], 32'hFFFF_FEFB);

    // Error on second beat, then a clean refill
    ar_delay = 0; r_delay = 0; err_addr = 32'h0000_0204;
    fb = f_idx.size(); db = dq.size();
    refill(32'h0000_0200);
    chk("t3_nfill", 32'(f_idx.size() - fb), 32'd4);
    chk("t3_d1", f_data[fb+1], 32'hFFFF_FDFB);
    chk("t3_d3", f_data[fb+3], 32'hFFFF_FDF3);
    chk("t3_done_err", 32'(dq[db]), 32'd1);
    err_addr = 32'h1;
    db = dq.size();
    refill(32'h0000_0300);
    chk("t3_clean_err", 32'(dq[db]), 32'd0);

    // Asynchronous reset while in R after two beats
    r_delay = 2;
    fb = f_idx.size(); qb = acc_q.size(); d0 = done_n;
    @(posedge clk); #1;
    req_addr = 32'h0000_0500; req_valid = 1'b1;
    k = 0;
    while (acc_q.size() == qb && k < 50) begin @(posedge clk); #1; k++; end
    req_valid = 1'b0;
    k = 0;
    while (!(f_idx.size() == fb + 2 && m_r_ready) && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk("t4_reach_r", 32'(k < 100), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t4_req_ready", 32'(req_ready), 32'd1);
    chk("t4_r_ready", 32'(m_r_ready), 32'd0);
    chk("t4_ar", {31'd0, m_ar_valid} | m_ar_addr, 32'd0);
    chk("t4_fill", {31'd0, fill_we} | fill_data, 32'd0);
    chk("t4_done", 32'({done, done_err}), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_no_done", 32'(done_n - d0), 32'd0);
    rst = 1'b1;
    r_delay = 0;
    fb = f_idx.size(); ab = ar_log.size(); db = dq.size();
    refill(32'h0000_0080);
    chk("t4_ar0", ar_log[ab], 32'h80);
    chk("t4_ar3", ar_log[ab+3], 32'h8C);
    chk("t4_nfill", 32'(f_idx.size() - fb), 32'd4);
    chk("t4_done_err", 32'(dq[db]), 32'd0);

    // Spurious R beat in IDLE, then back-to-back refills
    fb = f_idx.size();
    @(posedge clk); #1;
    spur_req++;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_spur_fill", 32'(f_idx.size() - fb), 32'd0);
    chk("t5_spur_idle", 32'(req_ready), 32'd1);
    qb = acc_q.size(); db = dq.size(); d0 = done_n;
    req_addr = 32'h0000_0600; req_valid = 1'b1;
    k = 0;
    while (acc_q.size() < qb + 2 && k < 100) begin @(posedge clk); #1; k++; end
    req_valid = 1'b0;
    k = 0;
    while (done_n < d0 + 2 && k < 100) begin @(posedge clk); #1; k++; end
    chk("t5_timeout", 32'(k < 100), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_ndone", 32'(done_n - d0), 32'd2);
    chk("t5_nfill", 32'(f_idx.size() - fb), 32'd8);
    chk("t5_gap", 32'(acc_q[qb+1] - done_cyc[db]), 32'd1);
    chk("t5_period", 32'(acc_q[qb+1] - acc_q[qb]), 32'd10);

    // Line at the top of the address space
    fb = f_idx.size(); ab = ar_log.size();
    refill(32'hFFFF_FFF4);
    chk("t6_ar0", ar_log[ab+0], 32'hFFFF_FFF0);
    chk("t6_ar1", ar_log[ab+1], 32'hFFFF_FFF4);
    chk("t6_ar2", ar_log[ab+2], 32'hFFFF_FFF8);
    chk("t6_ar3", ar_log[ab+3], 32'hFFFF_FFFC);
    chk("t6_d3", f_data[fb+3], 32'h0000_0003);

    chk("consec_fill_we", 32'(consec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
